// File: rtl/bus_demux4_if.sv
// Bus bundle between one initiator, the demux and four targets.
// The slave modport is the demux view; the master modport is the
// environment view that drives requests and models the targets.
interface bus_demux4_if;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         req_we;
  logic [31:0]  req_wdata;
  logic [3:0]   req_wstrb;

  logic [3:0]   tgt_valid;
  logic [3:0]   tgt_ready;
  logic [31:0]  tgt_addr;
  logic         tgt_we;
  logic [31:0]  tgt_wdata;
  logic [3:0]   tgt_wstrb;
  logic [3:0]   tgt_rvalid;
  logic [127:0] tgt_rdata;

  logic         rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_wstrb,
    output req_ready,
    output tgt_valid, tgt_addr, tgt_we, tgt_wdata, tgt_wstrb,
    input  tgt_ready, tgt_rvalid, tgt_rdata,
    output rsp_valid, rsp_rdata, rsp_err
  );

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_wstrb,
    input  req_ready,
    input  tgt_valid, tgt_addr, tgt_we, tgt_wdata, tgt_wstrb,
    output tgt_ready, tgt_rvalid, tgt_rdata,
    input  rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/bus_demux4.sv
// One-to-four request demultiplexer with a single outstanding transaction.
// The top address nibble picks a target; unmapped addresses and targets
// that stall past TIMEOUT cycles are answered with an error response.
module bus_demux4 #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input logic          clk,
  input logic          resetn,
  bus_demux4_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    ERR,
    RESP
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [1:0]  sel;
  logic [7:0]  count;
  logic [31:0] addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [1:0]  dec_sel;
  logic        dec_hit;
  logic        accept;
  logic        sel_ready;
  logic        sel_rvalid;
  logic [31:0] sel_rdata;
  logic        timeout_hit;

  // Map the target-select nibble onto a 2-bit target index
  always_comb begin
    dec_sel = 2'd0;
    dec_hit = 1'b1;
    case (bus.req_addr[31:28])
      4'h0:    dec_sel = 2'd0;
      4'h1:    dec_sel = 2'd1;
      4'h2:    dec_sel = 2'd2;
      4'hF:    dec_sel = 2'd3;
      default: dec_hit = 1'b0;
    endcase
  end

  assign accept      = (state == IDLE) && bus.req_valid;
  assign sel_ready   = bus.tgt_ready[sel];
  assign sel_rvalid  = bus.tgt_rvalid[sel];
  assign sel_rdata   = bus.tgt_rdata[{sel, 5'd0} +: 32];
  assign timeout_hit = (count == (TIMEOUT - 8'd1));

  // State register; reset abandons any in-flight transaction silently
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state decision; the timeout wins over a same-cycle ready or rvalid
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) state_next = dec_hit ? REQ : ERR;
      end
      REQ: begin
        if (timeout_hit)                  state_next = ERR;
        else if (sel_ready && sel_rvalid) state_next = RESP;
        else if (sel_ready)               state_next = WAIT;
      end
      WAIT: begin
        if (timeout_hit)     state_next = ERR;
        else if (sel_rvalid) state_next = RESP;
      end
      ERR:     state_next = IDLE;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the accepted request so the target sees stable fields
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel     <= 2'd0;
      addr_q  <= 32'd0;
      we_q    <= 1'b0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
    end else if (accept) begin
      sel     <= dec_sel;
      addr_q  <= bus.req_addr;
      we_q    <= bus.req_we;
      wdata_q <= bus.req_wdata;
      wstrb_q <= bus.req_wstrb;
    end
  end

  // Timeout counter runs only while a target owes us an answer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                             count <= 8'd0;
    else if (state == REQ || state == WAIT)  count <= count + 8'd1;
    else                                     count <= 8'd0;
  end

  // Response data and error flag persist until the next completion
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (state_next == RESP && state != RESP) begin
      rdata_q <= sel_rdata;
      err_q   <= 1'b0;
    end else if (state_next == ERR && state != ERR) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b1;
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.tgt_valid = (state == REQ) ? (4'b0001 << sel) : 4'b0000;
  assign bus.tgt_addr  = addr_q;
  assign bus.tgt_we    = we_q;
  assign bus.tgt_wdata = wdata_q;
  assign bus.tgt_wstrb = wstrb_q;
  assign bus.rsp_valid = (state == RESP) || (state == ERR);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_bus_demux4.sv
// Bench for bus_demux4: a default-timeout instance is checked through a
// response scoreboard plus timing checks, and a TIMEOUT=4 instance covers
// the stall-to-error path.
module tb_bus_demux4;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic resetn;
  int   compare_count;
  int   mismatch_count;
  exp_t exp_q[$];

  bus_demux4_if bus ();
  bus_demux4_if bus_t ();

  bus_demux4 dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  bus_demux4 #(.TIMEOUT(8'd4)) dut_t (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_t)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    compare_count++;
    if (got !== want) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request on the main bus for a single cycle
  task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input logic expect_rsp,
                               input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_we    = we;
    bus.req_wdata = wdata;
    bus.req_wstrb = wstrb;
    checkOutput("req_ready_at_accept", 32'(bus.req_ready), 32'd1);
    if (expect_rsp) begin
      e.rdata = exp_rdata;
      e.err   = exp_err;
      exp_q.push_back(e);
    end
    tick();
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h3000_0000;
    bus.req_we    = ~we;
    bus.req_wdata = 32'hFFFF_FFFF;
    bus.req_wstrb = 4'hF;
  endtask

  // Scoreboard: every response on the main bus must match the oldest expectation
  always @(negedge clk) begin
    if (bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("sb_rsp_rdata", bus.rsp_rdata, e.rdata);
        checkOutput("sb_rsp_err", 32'(bus.rsp_err), 32'(e.err));
      end
    end
  end

  // Guard against a stuck run
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compare_count  = 0;
    mismatch_count = 0;
    resetn         = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_we     = 1'b0;
    bus.req_wdata  = 32'd0;
    bus.req_wstrb  = 4'd0;
    bus.tgt_ready  = 4'd0;
    bus.tgt_rvalid = 4'd0;
    bus.tgt_rdata  = '0;
    bus_t.req_valid  = 1'b0;
    bus_t.req_addr   = 32'd0;
    bus_t.req_we     = 1'b0;
    bus_t.req_wdata  = 32'd0;
    bus_t.req_wstrb  = 4'd0;
    bus_t.tgt_ready  = 4'd0;
    bus_t.tgt_rvalid = 4'd0;
    bus_t.tgt_rdata  = '0;

    // Reset values
    tick();
    tick();
    checkOutput("rst_tgt_valid", 32'(bus.tgt_valid), 32'd0);
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    checkOutput("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    checkOutput("rst_tgt_addr", bus.tgt_addr, 32'd0);
    checkOutput("rst_tgt_wdata", bus.tgt_wdata, 32'd0);
    checkOutput("rst_tgt_we", 32'(bus.tgt_we), 32'd0);
    checkOutput("rst_tgt_wstrb", 32'(bus.tgt_wstrb), 32'd0);
    resetn = 1'b1;
    tick();
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);

    // Stray target strobes while idle must not produce a response
    bus.tgt_ready  = 4'hF;
    bus.tgt_rvalid = 4'hF;
    tick();
    bus.tgt_ready  = 4'h0;
    bus.tgt_rvalid = 4'h0;
    checkOutput("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);

    // Zero-wait read from target 1
    bus.tgt_rdata = {32'h1111_1111, 32'h2222_2222, 32'hDEAD_BEEF, 32'h4444_4444};
    applyStimulus(32'h1000_0040, 1'b0, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    checkOutput("rd_tgt_valid", 32'(bus.tgt_valid), 32'h2);
    checkOutput("rd_tgt_addr", bus.tgt_addr, 32'h1000_0040);
    checkOutput("rd_tgt_we", 32'(bus.tgt_we), 32'd0);
    checkOutput("rd_req_ready_busy", 32'(bus.req_ready), 32'd0);
    bus.tgt_ready  = 4'b0010;
    bus.tgt_rvalid = 4'b0010;
    tick();
    bus.tgt_ready  = 4'b0000;
    bus.tgt_rvalid = 4'b0000;
    checkOutput("rd_tgt_valid_drop", 32'(bus.tgt_valid), 32'd0);
    checkOutput("rd_rsp_latency", 32'(bus.rsp_valid), 32'd1);
    tick();
    checkOutput("rd_rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rd_rsp_rdata_hold", bus.rsp_rdata, 32'hDEAD_BEEF);

    // Write to target 3 with three stall cycles and a two-cycle wait
    bus.tgt_rdata = {32'h0000_1234, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC};
    applyStimulus(32'hF000_0004, 1'b1, 32'h0000_0055, 4'b0001, 1'b1, 32'h0000_1234, 1'b0);
    checkOutput("wr_tgt_wdata", bus.tgt_wdata, 32'h55);
    checkOutput("wr_tgt_wstrb", 32'(bus.tgt_wstrb), 32'h1);
    checkOutput("wr_tgt_we", 32'(bus.tgt_we), 32'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("wr_tgt_valid_held", 32'(bus.tgt_valid), 32'h8);
      if (i == 3) bus.tgt_ready = 4'b1000;
      tick();
    end
    bus.tgt_ready = 4'b0000;
    checkOutput("wr_wait_tgt_valid", 32'(bus.tgt_valid), 32'd0);
    checkOutput("wr_wait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    bus.tgt_rvalid = 4'b1000;
    tick();
    bus.tgt_rvalid = 4'b0000;
    checkOutput("wr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    tick();
    checkOutput("wr_rsp_single", 32'(bus.rsp_valid), 32'd0);

    // Unmapped read answers with an error the cycle after acceptance
    applyStimulus(32'h5000_0000, 1'b0, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1);
    checkOutput("unm_tgt_valid", 32'(bus.tgt_valid), 32'd0);
    checkOutput("unm_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("unm_rsp_err", 32'(bus.rsp_err), 32'd1);
    checkOutput("unm_rsp_rdata", bus.rsp_rdata, 32'd0);
    tick();
    checkOutput("unm_rsp_done", 32'(bus.rsp_valid), 32'd0);
    checkOutput("unm_err_hold", 32'(bus.rsp_err), 32'd1);

    // Target 0 in WAIT ignores completions from target 2
    bus.tgt_rdata = {32'h9999_9999, 32'h8888_8888, 32'h7777_7777, 32'hCAFE_0000};
    applyStimulus(32'h0000_0010, 1'b0, 32'h0, 4'h0, 1'b1, 32'hCAFE_0000, 1'b0);
    checkOutput("x_tgt_valid", 32'(bus.tgt_valid), 32'h1);
    bus.tgt_ready  = 4'b0001;
    bus.tgt_rvalid = 4'b0100;
    tick();
    bus.tgt_ready = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      checkOutput("x_no_rsp", 32'(bus.rsp_valid), 32'd0);
      tick();
    end
    bus.tgt_rvalid = 4'b0001;
    tick();
    bus.tgt_rvalid = 4'b0000;
    checkOutput("x_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    tick();

    // Reset asserted mid-transaction while waiting on target 0
    applyStimulus(32'h0000_0100, 1'b1, 32'h0000_A5A5, 4'hF, 1'b0, 32'h0, 1'b0);
    bus.tgt_ready = 4'b0001;
    tick();
    bus.tgt_ready = 4'b0000;
    checkOutput("rw_wait_tgt_valid", 32'(bus.tgt_valid), 32'd0);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("ar_tgt_addr", bus.tgt_addr, 32'd0);
    checkOutput("ar_tgt_wdata", bus.tgt_wdata, 32'd0);
    checkOutput("ar_tgt_we", 32'(bus.tgt_we), 32'd0);
    checkOutput("ar_tgt_wstrb", 32'(bus.tgt_wstrb), 32'd0);
    checkOutput("ar_rsp_rdata", bus.rsp_rdata, 32'd0);
    checkOutput("ar_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("ar_tgt_valid", 32'(bus.tgt_valid), 32'd0);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    bus.tgt_rvalid = 4'b0001;
    tick();
    bus.tgt_rvalid = 4'b0000;
    checkOutput("ar_late_rvalid", 32'(bus.rsp_valid), 32'd0);
    tick();
    checkOutput("ar_late_rvalid2", 32'(bus.rsp_valid), 32'd0);
    checkOutput("ar_req_ready", 32'(bus.req_ready), 32'd1);

    // TIMEOUT=4: target 2 never answers
    bus_t.tgt_rdata = {32'h0, 32'h1111_2222, 32'h0, 32'h7777_0001};
    bus_t.req_valid = 1'b1;
    bus_t.req_addr  = 32'h2000_0000;
    checkOutput("to_req_ready", 32'(bus_t.req_ready), 32'd1);
    tick();
    bus_t.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("to_tgt_valid", 32'(bus_t.tgt_valid), 32'h4);
      checkOutput("to_no_rsp", 32'(bus_t.rsp_valid), 32'd0);
      tick();
    end
    checkOutput("to_rsp_valid", 32'(bus_t.rsp_valid), 32'd1);
    checkOutput("to_rsp_err", 32'(bus_t.rsp_err), 32'd1);
    checkOutput("to_rsp_rdata", bus_t.rsp_rdata, 32'd0);
    checkOutput("to_tgt_valid_off", 32'(bus_t.tgt_valid), 32'd0);
    tick();
    checkOutput("to_rsp_done", 32'(bus_t.rsp_valid), 32'd0);
    checkOutput("to_req_ready_after", 32'(bus_t.req_ready), 32'd1);

    // TIMEOUT=4: rvalid in the final WAIT cycle loses to the timeout
    bus_t.req_valid = 1'b1;
    bus_t.req_addr  = 32'h2000_0008;
    tick();
    bus_t.req_valid = 1'b0;
    bus_t.tgt_ready = 4'b0100;
    tick();
    bus_t.tgt_ready = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      checkOutput("tp_wait_no_rsp", 32'(bus_t.rsp_valid), 32'd0);
      if (i == 2) bus_t.tgt_rvalid = 4'b0100;
      tick();
    end
    bus_t.tgt_rvalid = 4'b0000;
    checkOutput("tp_rsp_valid", 32'(bus_t.rsp_valid), 32'd1);
    checkOutput("tp_rsp_err", 32'(bus_t.rsp_err), 32'd1);
    checkOutput("tp_rsp_rdata", bus_t.rsp_rdata, 32'd0);
    tick();

    // TIMEOUT=4: normal transaction still completes afterwards
    bus_t.req_valid = 1'b1;
    bus_t.req_addr  = 32'h0000_0000;
    checkOutput("tn_req_ready", 32'(bus_t.req_ready), 32'd1);
    tick();
    bus_t.req_valid  = 1'b0;
    bus_t.tgt_ready  = 4'b0001;
    bus_t.tgt_rvalid = 4'b0001;
    tick();
    bus_t.tgt_ready  = 4'b0000;
    bus_t.tgt_rvalid = 4'b0000;
    checkOutput("tn_rsp_valid", 32'(bus_t.rsp_valid), 32'd1);
    checkOutput("tn_rsp_err", 32'(bus_t.rsp_err), 32'd0);
    checkOutput("tn_rsp_rdata", bus_t.rsp_rdata, 32'h7777_0001);
    tick();
    tick();

    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
